// File: rtl/sad_search_unit_if.sv
// Bus bundle for sad_search_unit: search control, the difference stream
// handshake and the best-match result handshake.
//   slave  : seen by the SAD unit (start/diff/diff_valid/best_ready in,
//            everything else out)
//   master : seen by the driver/controller side (directions reversed)
interface sad_search_unit_if #(
  parameter int unsigned DW       = 8,
  parameter int unsigned N        = 16,
  parameter int unsigned NUM_CAND = 4
);
  localparam int unsigned SW = DW + $clog2(N);
  localparam int unsigned IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  logic          start;
  logic [DW-1:0] diff;
  logic          diff_valid;
  logic          diff_ready;
  logic [SW-1:0] sad_out;
  logic          sad_valid;
  logic [SW-1:0] best_sad;
  logic [IW-1:0] best_idx;
  logic          best_valid;
  logic          best_ready;
  logic          busy;

  modport slave (
    input  start, diff, diff_valid, best_ready,
    output diff_ready, sad_out, sad_valid, best_sad, best_idx, best_valid, busy
  );

  modport master (
    output start, diff, diff_valid, best_ready,
    input  diff_ready, sad_out, sad_valid, best_sad, best_idx, best_valid, busy
  );
endinterface

// File: rtl/sad_search_unit.sv
// Sum-of-absolute-differences search: accumulates N differences per
// candidate block over NUM_CAND candidates, keeps the smallest SAD (earliest
// candidate wins ties) and offers it on a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sad_search_unit_if.slave (start, diff stream, per-candidate SAD
//           strobe, best result handshake, busy)
module sad_search_unit #(
  parameter int unsigned DW       = 8,
  parameter int unsigned N        = 16,
  parameter int unsigned NUM_CAND = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sad_search_unit_if.slave    bus
);
  localparam int unsigned SW = DW + $clog2(N);
  localparam int unsigned IW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int unsigned CW = $clog2(N);

  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [IW-1:0] CAND_LAST = IW'(NUM_CAND - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t        state;
  logic [SW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [IW-1:0] cand;

  logic          beat_c;
  logic [SW-1:0] acc_sum_c;

  assign beat_c    = bus.diff_valid && bus.diff_ready;
  // SW is sized for N full-scale beats, so this sum never wraps
  assign acc_sum_c = acc + SW'(bus.diff);

  // Search sequencer; all outputs are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      cand           <= '0;
      bus.best_sad   <= '0;
      bus.best_idx   <= '0;
      bus.sad_out    <= '0;
      bus.sad_valid  <= 1'b0;
      bus.best_valid <= 1'b0;
      bus.diff_ready <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.sad_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc            <= '0;
            cnt            <= '0;
            cand           <= '0;
            bus.best_sad   <= '1;
            bus.diff_ready <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat_c) begin
            acc <= acc_sum_c;
            if (cnt == CNT_LAST) begin
              // sad_out carries the completed sum during the COMPARE cycle
              bus.sad_out    <= acc_sum_c;
              bus.sad_valid  <= 1'b1;
              bus.diff_ready <= 1'b0;
              state          <= COMPARE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        COMPARE: begin
          // strict compare keeps the earlier candidate on a tie
          if (acc < bus.best_sad) begin
            bus.best_sad <= acc;
            bus.best_idx <= cand;
          end
          if (cand == CAND_LAST) begin
            bus.best_valid <= 1'b1;
            state          <= DONE;
          end else begin
            cand           <= cand + IW'(1);
            acc            <= '0;
            cnt            <= '0;
            bus.diff_ready <= 1'b1;
            state          <= ACCUM;
          end
        end
        DONE: begin
          if (bus.best_ready) begin
            bus.best_valid <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
